// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling 8N1 UART receiver feeding a show-ahead
// receive FIFO, with sticky framing-error and overrun flags.
module uart_rx_fifo #(
   parameter int BAUD_DIV   = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        RX,
   input  logic                        rd_en,
   input  logic                        err_clr,
   output logic [7:0]                  rd_data,
   output logic                        rx_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        frame_err,
   output logic                        overrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX  = DW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // Receiver state
   logic          sync1_q, sync2_q;
   logic          rx_s;
   state_t        state_q,    state_d;
   logic [DW-1:0] div_cnt_q,  div_cnt_d;
   logic [3:0]    samp_cnt_q, samp_cnt_d;
   logic [2:0]    bit_idx_q,  bit_idx_d;
   logic [7:0]    shift_q,    shift_d;
   logic          tick_s;
   logic [DW-1:0] div_next_s;
   logic          push_s;
   logic          fe_set_s;

   // FIFO state
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q,   overrun_d;
   logic          full_s;
   logic          pop_s;
   logic          wr_ok_s;
   logic          ovr_set_s;

   assign rx_s = sync2_q;

   // Oversample tick: the divider only runs while a character is being framed
   always_comb begin
      tick_s = (div_cnt_q == DIV_MAX);
      if (tick_s) begin
         div_next_s = '0;
      end else begin
         div_next_s = div_cnt_q + DW'(1);
      end
   end

   // Deframing FSM next-state: start validation, LSB-first shift, stop check
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      samp_cnt_d = samp_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      push_s     = 1'b0;
      fe_set_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            div_cnt_d  = '0;
            samp_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
            if (!rx_s) begin
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            div_cnt_d = div_next_s;
            if (tick_s) begin
               if (samp_cnt_q == 4'd7) begin
                  // Mid start bit: a high line here was only a glitch
                  samp_cnt_d = 4'd0;
                  bit_idx_d  = 3'd0;
                  if (rx_s) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  samp_cnt_d = samp_cnt_q + 4'd1;
               end
            end else begin
               samp_cnt_d = samp_cnt_q;
            end
         end
         S_DATA: begin
            div_cnt_d = div_next_s;
            if (tick_s) begin
               samp_cnt_d = samp_cnt_q + 4'd1;
               if (samp_cnt_q == 4'd15) begin
                  shift_d[bit_idx_q] = rx_s;
                  if (bit_idx_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q;
               end
            end else begin
               samp_cnt_d = samp_cnt_q;
            end
         end
         S_STOP: begin
            div_cnt_d = div_next_s;
            if (tick_s) begin
               samp_cnt_d = samp_cnt_q + 4'd1;
               if (samp_cnt_q == 4'd15) begin
                  if (rx_s) begin
                     push_s  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     fe_set_s = 1'b1;
                     state_d  = S_BREAK;
                  end
               end else begin
                  state_d = S_STOP;
               end
            end else begin
               samp_cnt_d = samp_cnt_q;
            end
         end
         S_BREAK: begin
            // Held-low line: report once, then wait for the line to go idle
            div_cnt_d  = '0;
            samp_cnt_d = 4'd0;
            if (rx_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d    = S_IDLE;
            div_cnt_d  = '0;
            samp_cnt_d = 4'd0;
            bit_idx_d  = 3'd0;
         end
      endcase
   end

   // FIFO bookkeeping: push/pop arbitration, pointers, count and sticky flags
   always_comb begin
      full_s    = (count_q == CNT_FULL);
      pop_s     = rd_en && (count_q != '0);
      wr_ok_s   = push_s && (!full_s || pop_s);
      ovr_set_s = push_s && full_s && !pop_s;

      if (wr_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A new error outranks a coincident clear
      if (fe_set_s) begin
         frame_err_d = 1'b1;
      end else if (err_clr) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end

      if (ovr_set_s) begin
         overrun_d = 1'b1;
      end else if (err_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State registers; reset abandons any partially received character
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         samp_cnt_q  <= 4'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= RX;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         samp_cnt_q  <= samp_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // FIFO storage; contents are only observable through the counted head
   always_ff @(posedge Clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   // Show-ahead head; forced to zero while empty so stale data never leaks
   always_comb begin
      if (count_q != '0) begin
         rd_data = mem_q[rd_ptr_q];
      end else begin
         rd_data = 8'h00;
      end
      rx_valid   = (count_q != '0);
      fifo_count = count_q;
      frame_err  = frame_err_q;
      overrun    = overrun_q;
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random bytes,
// compared against a queue-based reference of the receiver/FIFO behaviour.
module tb_uart_rx_fifo;

   localparam int DEPTH   = 8;
   localparam int BIT     = 128;        // clocks per bit at BAUD_DIV=8
   localparam int STOP_C  = 1218;       // cycle whose following edge samples the stop bit

   logic       Clk = 1'b0;
   logic       Rst;
   logic       RX;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic [3:0] fifo_count;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] mq[$];
   bit         m_fe = 1'b0;
   bit         m_ov = 1'b0;
   logic       v_before, v_after;

   uart_rx_fifo #(.BAUD_DIV(8), .FIFO_DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .RX(RX), .rd_en(rd_en), .err_clr(err_clr),
      .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
      chk({tag, ".valid"}, 32'(rx_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
      chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
   endtask

   // Serialise one 8N1 frame; optionally pulse rd_en / err_clr in the stop-sample cycle
   task automatic send(input logic [7:0] b, input bit stop, input bit rd_at_stop, input bit clr_at_stop);
      int  slot;
      int  sz;
      bit  pop_ok;
      bit  ov_set;
      sz     = mq.size();
      pop_ok = rd_at_stop && (sz > 0);
      ov_set = 1'b0;
      for (int c = 0; c < 10 * BIT; c++) begin
         slot = c / BIT;
         if (slot == 0)      RX = 1'b0;
         else if (slot <= 8) RX = b[slot-1];
         else                RX = stop;
         if (c == STOP_C)     v_before = rx_valid;
         if (c == STOP_C + 1) v_after  = rx_valid;
         rd_en   = rd_at_stop  && (c == STOP_C);
         err_clr = clr_at_stop && (c == STOP_C);
         step();
      end
      rd_en   = 1'b0;
      err_clr = 1'b0;
      if (pop_ok) void'(mq.pop_front());
      if (stop) begin
         if (sz == DEPTH && !pop_ok) ov_set = 1'b1;
         else                        mq.push_back(b);
      end
      m_fe = !stop  || (m_fe && !clr_at_stop);
      m_ov = ov_set || (m_ov && !clr_at_stop);
   endtask

   task automatic pop(input string tag);
      chk_state({tag, ".pre"});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      chk_state({tag, ".post"});
   endtask

   initial begin
      logic [7:0] rb;
      Rst = 1'b1; RX = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      v_before = 1'b0; v_after = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst.rd_data", 32'(rd_data), 32'h0);
      chk("rst.valid", 32'(rx_valid), 32'h0);
      chk("rst.count", 32'(fifo_count), 32'h0);
      chk("rst.frame_err", 32'(frame_err), 32'h0);
      chk("rst.overrun", 32'(overrun), 32'h0);
      Rst = 1'b0;
      idle(4);

      // Basic receive and exact start-edge-to-valid latency
      send(8'hA5, 1'b1, 1'b0, 1'b0);
      chk("lat.before", 32'(v_before), 32'h0);
      chk("lat.after", 32'(v_after), 32'h1);
      chk_state("a5");
      pop("a5.pop");

      // Short low glitch is a false start
      RX = 1'b0; idle(40);
      RX = 1'b1; idle(200);
      chk_state("glitch");
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      pop("glitch.3c");

      // Framing error with a held-low line reports once
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      chk_state("fe");
      idle(100);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      m_fe = 1'b0;
      chk_state("fe.clr");
      idle(284);
      chk_state("fe.held");
      RX = 1'b1; idle(20);
      chk_state("fe.idle");
      send(8'h5A, 1'b1, 1'b0, 1'b0);
      pop("fe.5a");

      // Overrun: nine bytes into eight entries, then set-beats-clear
      for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
      chk_state("ovr");
      send(8'h0A, 1'b1, 1'b0, 1'b1);
      chk_state("ovr.setwins");
      err_clr = 1'b1; step(); err_clr = 1'b0;
      m_ov = 1'b0;
      chk_state("ovr.clr");
      for (int i = 0; i < DEPTH; i++) pop("ovr.drain");
      rd_en = 1'b1; step(); rd_en = 1'b0;
      chk_state("empty.pop");

      // Push and pop together while empty: only the push lands
      send(8'hE7, 1'b1, 1'b1, 1'b0);
      chk_state("emptypp");
      pop("emptypp.e7");

      // Push and pop together while full: both land, no overrun
      for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
      send(8'h18, 1'b1, 1'b1, 1'b0);
      chk_state("fullpp");
      for (int i = 0; i < DEPTH; i++) pop("fullpp.drain");

      // Random bytes with random reads in between
      for (int i = 0; i < 10; i++) begin
         if (mq.size() != 0 && $urandom_range(0, 1) == 1) pop("rnd.pop");
         rb = 8'($urandom);
         send(rb, 1'b1, 1'b0, 1'b0);
         idle($urandom_range(1, 20));
         chk_state("rnd");
      end
      while (mq.size() != 0) pop("rnd.drain");
      if (m_ov) begin
         err_clr = 1'b1; step(); err_clr = 1'b0;
         m_ov = 1'b0;
      end

      // Asynchronous reset in the middle of a character
      send(8'h77, 1'b1, 1'b0, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      RX = 1'b1; idle(10);
      chk_state("prerst");
      for (int c = 0; c < 4 * BIT + 64; c++) begin
         if (c < BIT) RX = 1'b0;
         else         RX = rb[0] ^ c[7];
         step();
      end
      #3 Rst = 1'b1;
      #1;
      chk("arst.rd_data", 32'(rd_data), 32'h0);
      chk("arst.valid", 32'(rx_valid), 32'h0);
      chk("arst.count", 32'(fifo_count), 32'h0);
      chk("arst.frame_err", 32'(frame_err), 32'h0);
      chk("arst.overrun", 32'(overrun), 32'h0);
      mq.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
      @(posedge Clk);
      #1;
      RX = 1'b1;
      idle(3);
      Rst = 1'b0;
      idle(5);
      chk_state("postrst");
      send(8'hC3, 1'b1, 1'b0, 1'b0);
      chk_state("postrst.c3");
      pop("postrst.pop");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
